// File: rtl/atm_pkg.sv
// Shared types and constants for the two-terminal ATM transaction arbiter.
// Imported by the account store and the arbiter top.
package atm_pkg;

  localparam int BAL_W    = 18;
  localparam int AMT_W    = 12;
  localparam int CARD_W   = 3;
  localparam int NUM_ACCT = 8;

  localparam logic [AMT_W-1:0] MAX_TXN   = 12'd2000;
  localparam logic [BAL_W-1:0] RESET_BAL = 18'd1000;

  typedef enum logic [1:0] {
    OP_QUERY = 2'd0,
    OP_DEP   = 2'd1,
    OP_WDR   = 2'd2,
    OP_ILL   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_CARD  = 2'd1,
    ERR_LIMIT = 2'd2,
    ERR_FUNDS = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              term;
    logic [1:0]        op;
    logic [CARD_W-1:0] card;
    logic [AMT_W-1:0]  amt;
  } txn_t;

  typedef struct packed {
    logic             acc;
    logic [1:0]       err;
    logic [BAL_W-1:0] bal;
  } res_t;

  function automatic logic card_ok(input logic [CARD_W-1:0] c);
    return (c >= 3'd1) && (c <= 3'd5);
  endfunction

endpackage

// File: rtl/atm_account_store.sv
// Eight 18-bit account balances with one registered read port
// and one write port; reset reloads the opening balances.
module atm_account_store
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [CARD_W-1:0] rd_addr,
  output logic [BAL_W-1:0]  rd_data,
  input  logic              we,
  input  logic [CARD_W-1:0] wr_addr,
  input  logic [BAL_W-1:0]  wr_data
);

  logic [BAL_W-1:0] mem_q [NUM_ACCT];
  logic [BAL_W-1:0] mem_d [NUM_ACCT];
  logic [BAL_W-1:0] rd_data_q;
  logic [BAL_W-1:0] rd_data_d;

  // Next array contents and read register; read holds when idle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  // Reset loads live cards with the opening balance, others with 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        mem_q[i] <= card_ok(CARD_W'(i)) ? RESET_BAL : '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/atm_txn_arbiter.sv
// Serializes two ATM terminals onto one shared account store.
// Each transaction walks IDLE -> READ -> EXEC -> DONE.
module atm_txn_arbiter
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  input  logic [CARD_W-1:0] card0,
  input  logic [CARD_W-1:0] card1,
  input  logic [AMT_W-1:0]  amt0,
  input  logic [AMT_W-1:0]  amt1,
  output logic [1:0]        done,
  output logic              accepted,
  output logic [1:0]        err,
  output logic [BAL_W-1:0]  balance,
  output logic              busy
);

  state_e           state_q, state_d;
  txn_t             txn_q, txn_d;
  res_t             res_q, res_d;
  logic             prio_q, prio_d;
  logic [1:0]       done_q, done_d;
  logic             both, gnt;
  logic [BAL_W-1:0] rd_data;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   sum;
  logic             we;

  // Sequencing and grant; priority only rotates on contested grants,
  // so a lone request never steals the other terminal's next turn.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    prio_d  = prio_q;
    both    = req0 & req1;
    gnt     = both ? prio_q : req1;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          txn_d.term = gnt;
          txn_d.op   = gnt ? op1 : op0;
          txn_d.card = gnt ? card1 : card0;
          txn_d.amt  = gnt ? amt1 : amt0;
          state_d    = ST_READ;
          if (both) begin
            prio_d = ~gnt;
          end
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction rules evaluated on the freshly read balance.
  always_comb begin
    amt_ext = BAL_W'(txn_q.amt);
    sum     = {1'b0, rd_data} + {1'b0, amt_ext};
    res_d   = '0;
    done_d  = '0;
    if (state_q == ST_EXEC) begin
      done_d    = txn_q.term ? 2'b10 : 2'b01;
      res_d.bal = rd_data;
      res_d.err = ERR_OK;
      if (!card_ok(txn_q.card) || txn_q.op == OP_ILL) begin
        res_d.err = ERR_CARD;
      end else if (txn_q.op == OP_QUERY) begin
        res_d.acc = 1'b1;
      end else if (txn_q.amt == '0 || txn_q.amt > MAX_TXN) begin
        res_d.err = ERR_LIMIT;
      end else if (txn_q.op == OP_DEP) begin
        if (sum[BAL_W]) begin
          res_d.err = ERR_LIMIT;
        end else begin
          res_d.acc = 1'b1;
          res_d.bal = sum[BAL_W-1:0];
        end
      end else if (amt_ext > rd_data) begin
        res_d.err = ERR_FUNDS;
      end else begin
        res_d.acc = 1'b1;
        res_d.bal = rd_data - amt_ext;
      end
    end
  end

  // State, latched request and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      prio_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      prio_q  <= prio_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign we = (state_q == ST_DONE) && res_q.acc
           && (txn_q.op != OP_QUERY);

  atm_account_store u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (state_q == ST_READ),
    .rd_addr (txn_q.card),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (txn_q.card),
    .wr_data (res_q.bal)
  );

  assign done     = done_q;
  assign accepted = res_q.acc;
  assign err      = res_q.err;
  assign balance  = res_q.bal;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Scoreboard bench for atm_txn_arbiter: directed scenarios
// plus randomized rounds against a queue-based account model.
module tb_atm_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [2:0]  card0 = '0, card1 = '0;
  logic [11:0] amt0 = '0, amt1 = '0;
  logic [1:0]  done;
  logic        accepted;
  logic [1:0]  err;
  logic [17:0] balance;
  logic        busy;

  typedef struct {
    logic [1:0]  done;
    logic        acc;
    logic [1:0]  err;
    logic [17:0] bal;
  } exp_t;

  exp_t exp_q[$];
  int   mbal[8];
  int   prio;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  atm_txn_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .card0(card0), .card1(card1),
    .amt0(amt0), .amt1(amt1),
    .done(done), .accepted(accepted),
    .err(err), .balance(balance), .busy(busy)
  );

  task automatic chk(input string name,
                     input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mbal[i] = (i >= 1 && i <= 5) ? 1000 : 0;
    prio = 0;
  endfunction

  // Account rules applied to the model balances in service order.
  function automatic exp_t model(int t, int op, int card, int amt);
    exp_t e;
    e.done = (t == 0) ? 2'b01 : 2'b10;
    e.acc  = 1'b0;
    e.err  = 2'd0;
    if (card < 1 || card > 5 || op == 3) e.err = 2'd1;
    else if (op == 0) e.acc = 1'b1;
    else if (amt == 0 || amt > 2000) e.err = 2'd2;
    else if (op == 1) begin
      if (mbal[card] + amt > 262143) e.err = 2'd2;
      else begin e.acc = 1'b1; mbal[card] += amt; end
    end else begin
      if (amt > mbal[card]) e.err = 2'd3;
      else begin e.acc = 1'b1; mbal[card] -= amt; end
    end
    e.bal = 18'(mbal[card]);
    return e;
  endfunction

  // Monitor: pops on each done pulse, otherwise outputs must be 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {done, accepted, err, balance}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", {done, accepted, err, balance},
              {e.done, e.acc, e.err, e.bal});
        end
      end else begin
        chk("idle_outputs", {accepted, err, balance}, 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {done, accepted, err, balance, busy}, 0);
    chk("reset_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b0;
    model_reset();
  endtask

  // One round: one or both terminals request in the same cycle.
  task automatic run_round(bit r0, bit r1,
                           int o0, int c0, int a0,
                           int o1, int c1, int a1);
    int first, k, cyc;
    @(negedge clk);
    chk("busy_idle", busy, 0);
    op0 = 2'(o0); card0 = 3'(c0); amt0 = 12'(a0);
    op1 = 2'(o1); card1 = 3'(c1); amt1 = 12'(a1);
    req0 = r0; req1 = r1;
    if (r0 && r1) begin
      first = prio;
      prio = 1 - prio;
    end else begin
      first = r1 ? 1 : 0;
    end
    if (first == 0) exp_q.push_back(model(0, o0, c0, a0));
    else            exp_q.push_back(model(1, o1, c1, a1));
    if (r0 && r1) begin
      if (first == 0) exp_q.push_back(model(1, o1, c1, a1));
      else            exp_q.push_back(model(0, o0, c0, a0));
    end
    k = 0; cyc = 0;
    while ((req0 || req1) && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_read", busy, 1);
      if (done != 2'b00) begin
        chk("latency", cyc, 3 + 4 * k);
        k++;
        if (done[0]) req0 = 1'b0;
        if (done[1]) req1 = 1'b0;
      end
    end
    if (req0 || req1) begin
      chk("round_timeout", {req0, req1}, 0);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic t0(int o, int c, int a);
    run_round(1, 0, o, c, a, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    // query, deposit, withdraw, limit, funds, bad card
    t0(0, 1, 0);
    t0(1, 1, 500);
    t0(2, 1, 200);
    t0(1, 4, 3000);
    t0(2, 3, 1500);
    t0(1, 6, 500);
    t0(0, 6, 0);
    t0(3, 2, 10);
    t0(1, 2, 0);
    t0(1, 2, 2000);
    t0(2, 2, 2001);
    // withdraw to exactly zero, then one more
    t0(2, 3, 1000);
    t0(2, 3, 1);
    // deposit up to the 18-bit ceiling on card 5
    for (int i = 0; i < 131; i++) run_round(0, 1, 0, 0, 0, 1, 5, 2000);
    run_round(0, 1, 0, 0, 0, 1, 5, 1143);
    run_round(0, 1, 0, 0, 0, 1, 5, 1);
    run_round(0, 1, 0, 0, 0, 0, 5, 0);
    // reset during EXEC of a card 1 deposit aborts it
    @(negedge clk);
    op0 = 2'd1; card0 = 3'd1; amt0 = 12'd500; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_no_done", {done, busy}, 0);
    req0 = 1'b0;
    rst = 1'b0;
    model_reset();
    // contested pair on card 2, then the next pair flips order
    run_round(1, 1, 1, 2, 100, 2, 2, 500);
    run_round(1, 1, 0, 2, 0, 0, 2, 0);
    t0(0, 1, 0);
    // randomized rounds
    for (int n = 0; n < 200; n++) begin
      int sel, o[2], c[2], a[2];
      sel = $urandom_range(0, 2);
      for (int t = 0; t < 2; t++) begin
        o[t] = $urandom_range(0, 3);
        c[t] = $urandom_range(0, 7);
        case ($urandom_range(0, 3))
          0: a[t] = $urandom_range(0, 2000);
          1: a[t] = $urandom_range(1990, 2010);
          2: a[t] = $urandom_range(0, 4095);
          default: a[t] = $urandom_range(0, 50);
        endcase
      end
      if ($urandom_range(0, 1) == 1) c[1] = c[0];
      run_round(sel != 1, sel != 0, o[0], c[0], a[0], o[1], c[1], a[1]);
    end
    repeat (6) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
